// File: rtl/boot_verifier_pkg.sv
// Shared encodings for the bootstrap path: region codes, FSM states and bus widths.
// Imported by the verifier and reused by the bootstrapper.
package boot_verifier_pkg;

  localparam int ADDR_W      = 17;
  localparam int CHECKSUM_W  = 16;
  localparam int NUM_REGIONS = 3;

  typedef enum logic [1:0] {
    REGION_SLICE     = 2'd0,
    REGION_LOOKAHEAD = 2'd1,
    REGION_CONTROL   = 2'd2
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FINISH
  } state_t;

endpackage

// File: rtl/boot_verifier_if.sv
// Bootstrap read-back bus: EEPROM/SRAM read lines plus verifier control and status.
// master = the verifier that owns the bus while BUSY; slave = memories and supervisor.
interface boot_verifier_if;
  import boot_verifier_pkg::*;

  logic                  START;
  logic                  N_BOOTED;
  logic [7:0]            ROM_DATA;
  logic [7:0]            RAM_DATA;
  logic [ADDR_W-1:0]     ADDR;
  logic [1:0]            REGION;
  logic                  ROM_N_OE;
  logic                  SLICE_N_OE;
  logic                  LOOKAHEAD_N_OE;
  logic                  CONTROL_N_OE;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERROR;
  logic [1:0]            ERR_REGION;
  logic [ADDR_W-1:0]     ERR_ADDR;
  logic [CHECKSUM_W-1:0] CHECKSUM;

  modport master (
    input  START, N_BOOTED, ROM_DATA, RAM_DATA,
    output ADDR, REGION, ROM_N_OE, SLICE_N_OE, LOOKAHEAD_N_OE, CONTROL_N_OE,
    output BUSY, DONE, ERROR, ERR_REGION, ERR_ADDR, CHECKSUM
  );

  modport slave (
    output START, N_BOOTED, ROM_DATA, RAM_DATA,
    input  ADDR, REGION, ROM_N_OE, SLICE_N_OE, LOOKAHEAD_N_OE, CONTROL_N_OE,
    input  BUSY, DONE, ERROR, ERR_REGION, ERR_ADDR, CHECKSUM
  );

endinterface

// File: rtl/boot_addr_seq.sv
// Byte address / region sequencer for the read-back pass. Walks every region in order,
// skipping zero-depth regions, and flags the final byte of the whole pass.
module boot_addr_seq
  import boot_verifier_pkg::*;
#(
  parameter int SLICE_DEPTH     = 65536,
  parameter int LOOKAHEAD_DEPTH = 4096,
  parameter int CONTROL_DEPTH   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic              last_byte,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_reg, addr_next;
  region_t           region_reg, region_next;
  logic [2:0]        first_region, following_region;
  logic              region_end;

  function automatic logic has_bytes(input int r);
    case (r)
      0:       return SLICE_DEPTH > 0;
      1:       return LOOKAHEAD_DEPTH > 0;
      2:       return CONTROL_DEPTH > 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] last_addr(input region_t r);
    case (r)
      REGION_SLICE:     return ADDR_W'(SLICE_DEPTH - 1);
      REGION_LOOKAHEAD: return ADDR_W'(LOOKAHEAD_DEPTH - 1);
      default:          return ADDR_W'(CONTROL_DEPTH - 1);
    endcase
  endfunction

  // Lowest region at or after 'from' that holds bytes; 3 means nothing left.
  function automatic logic [2:0] next_live(input logic [2:0] from);
    logic [2:0] result;
    result = 3'd3;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (3'(r) >= from && has_bytes(r)) result = 3'(r);
    end
    return result;
  endfunction

  assign first_region     = next_live(3'd0);
  assign following_region = next_live(3'(region_reg) + 3'd1);
  assign region_end       = (addr_reg == last_addr(region_reg));
  assign last_byte        = region_end && (following_region == 3'd3);
  assign empty            = (first_region == 3'd3);

  always_comb begin
    addr_next   = addr_reg;
    region_next = region_reg;
    if (clear) begin
      addr_next   = '0;
      region_next = empty ? REGION_SLICE : region_t'(first_region[1:0]);
    end else if (advance && !last_byte) begin
      if (region_end) begin
        addr_next   = '0;
        region_next = region_t'(following_region[1:0]);
      end else begin
        addr_next = addr_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      region_reg <= REGION_SLICE;
    end else begin
      addr_reg   <= addr_next;
      region_reg <= region_next;
    end
  end

  assign addr   = addr_reg;
  assign region = region_reg;

endmodule

// File: rtl/boot_verifier.sv
// Post-bootstrap read-back checker: re-reads EEPROM and SRAM byte pairs, compares them,
// sums the SRAM bytes and reports pass or the first failing region/address.
module boot_verifier
  import boot_verifier_pkg::*;
#(
  parameter int SLICE_DEPTH     = 65536,
  parameter int LOOKAHEAD_DEPTH = 4096,
  parameter int CONTROL_DEPTH   = 4096,
  parameter int READ_LATENCY    = 2
) (
  input logic             CLK,
  input logic             RST,
  boot_verifier_if.master bus
);

  localparam int              LAT_W    = $clog2(READ_LATENCY) + 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_t                state_reg, state_next;
  logic                  arm_reg;
  logic [LAT_W-1:0]      lat_cnt_reg;
  logic [7:0]            rom_byte_reg, ram_byte_reg;
  logic                  done_reg, error_reg;
  logic [1:0]            err_region_reg;
  logic [ADDR_W-1:0]     err_addr_reg;
  logic [CHECKSUM_W-1:0] checksum_reg;

  logic busy, mismatch;
  logic start_accept, seq_advance, capture, check_en, abort;

  logic [ADDR_W-1:0]      seq_addr;
  region_t                seq_region;
  logic                   seq_last, seq_empty;
  logic [NUM_REGIONS-1:0] sram_n_oe;

  boot_addr_seq #(
    .SLICE_DEPTH    (SLICE_DEPTH),
    .LOOKAHEAD_DEPTH(LOOKAHEAD_DEPTH),
    .CONTROL_DEPTH  (CONTROL_DEPTH)
  ) u_addr_seq (
    .clk      (CLK),
    .rst      (RST),
    .clear    (start_accept),
    .advance  (seq_advance),
    .addr     (seq_addr),
    .region   (seq_region),
    .last_byte(seq_last),
    .empty    (seq_empty)
  );

  assign busy     = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == CHECK);
  assign mismatch = (rom_byte_reg != ram_byte_reg);

  // An accepted START spends one IDLE cycle armed before the first ISSUE.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    seq_advance  = 1'b0;
    capture      = 1'b0;
    check_en     = 1'b0;
    abort        = 1'b0;
    if (busy && bus.N_BOOTED) begin
      abort      = 1'b1;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm_reg) begin
            state_next = seq_empty ? FINISH : ISSUE;
          end else if (bus.START && !bus.N_BOOTED) begin
            start_accept = 1'b1;
          end
        end
        ISSUE: state_next = WAIT;
        WAIT: begin
          if (lat_cnt_reg == LAT_LAST) begin
            capture    = 1'b1;
            state_next = CHECK;
          end
        end
        CHECK: begin
          check_en = 1'b1;
          if (mismatch || seq_last) begin
            state_next = FINISH;
          end else begin
            seq_advance = 1'b1;
            state_next  = ISSUE;
          end
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      arm_reg        <= 1'b0;
      lat_cnt_reg    <= '0;
      rom_byte_reg   <= '0;
      ram_byte_reg   <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      err_region_reg <= '0;
      err_addr_reg   <= '0;
      checksum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      arm_reg   <= start_accept;
      if (state_reg == ISSUE) lat_cnt_reg <= '0;
      else if (state_reg == WAIT) lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
      if (capture) begin
        rom_byte_reg <= bus.ROM_DATA;
        ram_byte_reg <= bus.RAM_DATA;
      end
      if (start_accept) begin
        done_reg       <= 1'b0;
        error_reg      <= 1'b0;
        err_region_reg <= '0;
        err_addr_reg   <= '0;
        checksum_reg   <= '0;
      end
      if (check_en) begin
        checksum_reg <= checksum_reg + CHECKSUM_W'(ram_byte_reg);
        if (mismatch) begin
          error_reg      <= 1'b1;
          err_region_reg <= seq_region;
          err_addr_reg   <= seq_addr;
        end
      end
      if (state_reg == FINISH) done_reg <= 1'b1;
      if (abort) begin
        done_reg  <= 1'b0;
        error_reg <= 1'b0;
      end
    end
  end

  // Only the current region's SRAM is enabled, and only while the bus is owned.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_sram_oe
      assign sram_n_oe[gi] = !(busy && (seq_region == region_t'(gi)));
    end
  endgenerate

  assign bus.ADDR           = seq_addr;
  assign bus.REGION         = seq_region;
  assign bus.ROM_N_OE       = !busy;
  assign bus.SLICE_N_OE     = sram_n_oe[REGION_SLICE];
  assign bus.LOOKAHEAD_N_OE = sram_n_oe[REGION_LOOKAHEAD];
  assign bus.CONTROL_N_OE   = sram_n_oe[REGION_CONTROL];
  assign bus.BUSY           = busy;
  assign bus.DONE           = done_reg;
  assign bus.ERROR          = error_reg;
  assign bus.ERR_REGION     = err_region_reg;
  assign bus.ERR_ADDR       = err_addr_reg;
  assign bus.CHECKSUM       = checksum_reg;

endmodule

// File: tb/tb_boot_verifier.sv
// Scoreboard bench for boot_verifier with 4/2/2-byte regions and read latency 2.
// Memory contents are ADDR + 16*REGION, with an optional single faulty SRAM byte.
module tb_boot_verifier;
  import boot_verifier_pkg::*;

  typedef struct {
    logic        err;
    logic [1:0]  region;
    logic [16:0] addr;
    logic [15:0] checksum;
    int          done_cyc;
  } expect_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  int   la_low_cycles = 0;
  int   ctrl_low_cycles = 0;
  logic done_prev = 1'b0;

  logic        fault_en;
  logic [1:0]  fault_region;
  logic [16:0] fault_addr;
  logic [7:0]  fault_val;
  logic [7:0]  base_byte;

  expect_t sb_q[$];

  boot_verifier_if bus();

  boot_verifier #(
    .SLICE_DEPTH    (4),
    .LOOKAHEAD_DEPTH(2),
    .CONTROL_DEPTH  (2),
    .READ_LATENCY   (2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign base_byte    = 8'({bus.REGION, 4'b0000}) + bus.ADDR[7:0];
  assign bus.ROM_DATA = bus.ROM_N_OE ? 8'h00 : base_byte;
  assign bus.RAM_DATA = (bus.SLICE_N_OE && bus.LOOKAHEAD_N_OE && bus.CONTROL_N_OE) ? 8'h00 :
                        (fault_en && bus.REGION == fault_region && bus.ADDR == fault_addr) ?
                        fault_val : base_byte;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", what, act, req, cyc);
    end
  endtask

  function automatic logic bus_ok();
    logic [2:0] low;
    low = {~bus.SLICE_N_OE, ~bus.LOOKAHEAD_N_OE, ~bus.CONTROL_N_OE};
    return ($countones(low) <= 1) && (bus.BUSY || (low == 3'b000 && bus.ROM_N_OE));
  endfunction

  // Monitor: bus-conflict check every cycle, and scoreboard compare on each DONE rise.
  always @(negedge clk) begin
    if (!rst) begin
      check("bus_conflict", 32'(bus_ok()), 32'd1);
      if (!bus.LOOKAHEAD_N_OE) la_low_cycles <= la_low_cycles + 1;
      if (!bus.CONTROL_N_OE) ctrl_low_cycles <= ctrl_low_cycles + 1;
      if (bus.DONE && !done_prev) begin
        n_txn <= n_txn + 1;
        $display("txn %0d: DONE at cycle %0d error=%0d err_region=%0d err_addr=%0d checksum=0x%04h",
                 n_txn, cyc, bus.ERROR, bus.ERR_REGION, bus.ERR_ADDR, bus.CHECKSUM);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.DONE), 32'd0);
        end else begin
          check("done_cycle", cyc, sb_q[0].done_cyc);
          check("error", 32'(bus.ERROR), 32'(sb_q[0].err));
          check("err_region", 32'(bus.ERR_REGION), 32'(sb_q[0].region));
          check("err_addr", 32'(bus.ERR_ADDR), 32'(sb_q[0].addr));
          check("checksum", 32'(bus.CHECKSUM), 32'(sb_q[0].checksum));
          sb_q.delete(0);
        end
      end
    end
    done_prev <= bus.DONE;
  end

  task automatic pulse_start(output int k);
    @(negedge clk);
    bus.START = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic expect_done(input logic err, input logic [1:0] region, input logic [16:0] addr,
                             input logic [15:0] checksum, input int done_cyc);
    sb_q.push_back('{err, region, addr, checksum, done_cyc});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, 32'(bus.ADDR), 32'd0);
    check({tag, "_region"}, 32'(bus.REGION), 32'd0);
    check({tag, "_n_oe"}, 32'({bus.ROM_N_OE, bus.SLICE_N_OE, bus.LOOKAHEAD_N_OE, bus.CONTROL_N_OE}), 32'hF);
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_done"}, 32'(bus.DONE), 32'd0);
    check({tag, "_error"}, 32'(bus.ERROR), 32'd0);
    check({tag, "_err_region"}, 32'(bus.ERR_REGION), 32'd0);
    check({tag, "_err_addr"}, 32'(bus.ERR_ADDR), 32'd0);
    check({tag, "_checksum"}, 32'(bus.CHECKSUM), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int la0, ctrl0;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.N_BOOTED = 1'b0;
    fault_en = 1'b0;
    fault_region = 2'd0;
    fault_addr = 17'd0;
    fault_val = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Clean pass: 8 bytes x 4 cycles; checksum 0+1+2+3 + 16+17 + 32+33 = 104 = 0x68.
    la0 = la_low_cycles;
    ctrl0 = ctrl_low_cycles;
    pulse_start(k);
    expect_done(1'b0, 2'd0, 17'd0, 16'h0068, k + 34);
    check("armed_busy", 32'(bus.BUSY), 32'd0);
    @(negedge clk);
    check("issue_busy", 32'(bus.BUSY), 32'd1);
    check("issue_rom_n_oe", 32'(bus.ROM_N_OE), 32'd0);
    check("issue_slice_n_oe", 32'(bus.SLICE_N_OE), 32'd0);
    drain(60);
    check("clean_la_oe_cycles", la_low_cycles - la0, 8);
    check("clean_ctrl_oe_cycles", ctrl_low_cycles - ctrl0, 8);

    // Slice byte 2 reads 0xFF from SRAM: checksum 0+1+0xFF = 0x100, stop after byte 2.
    fault_en = 1'b1;
    fault_region = 2'd0;
    fault_addr = 17'd2;
    fault_val = 8'hFF;
    la0 = la_low_cycles;
    ctrl0 = ctrl_low_cycles;
    pulse_start(k);
    expect_done(1'b1, 2'd0, 17'd2, 16'h0100, k + 14);
    drain(60);
    check("slice_err_la_oe_cycles", la_low_cycles - la0, 0);
    check("slice_err_ctrl_oe_cycles", ctrl_low_cycles - ctrl0, 0);

    // Control byte 1 reads 0x00 instead of 0x21: checksum 0x68 - 0x21 = 0x47.
    fault_region = 2'd2;
    fault_addr = 17'd1;
    fault_val = 8'h00;
    pulse_start(k);
    expect_done(1'b1, 2'd2, 17'd1, 16'h0047, k + 34);
    drain(60);

    // START while N_BOOTED is high is ignored; previous result stays held.
    fault_en = 1'b0;
    bus.N_BOOTED = 1'b1;
    pulse_start(k);
    repeat (2) @(negedge clk);
    check("nbooted_start_busy", 32'(bus.BUSY), 32'd0);
    check("nbooted_start_n_oe",
          32'({bus.ROM_N_OE, bus.SLICE_N_OE, bus.LOOKAHEAD_N_OE, bus.CONTROL_N_OE}), 32'hF);
    check("nbooted_start_done_held", 32'(bus.DONE), 32'd1);
    check("nbooted_start_error_held", 32'(bus.ERROR), 32'd1);
    bus.N_BOOTED = 1'b0;

    // Second START mid-pass must not restart the pass.
    pulse_start(k);
    expect_done(1'b0, 2'd0, 17'd0, 16'h0068, k + 34);
    repeat (6) @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    drain(60);

    // Reset during the first WAIT cycle of lookahead byte 0 (byte 4).
    pulse_start(k);
    repeat (18) @(negedge clk);
    check("pre_reset_region", 32'(bus.REGION), 32'd1);
    check("pre_reset_busy", 32'(bus.BUSY), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midpass_reset");
    rst = 1'b0;
    pulse_start(k);
    expect_done(1'b0, 2'd0, 17'd0, 16'h0068, k + 34);
    drain(60);

    // N_BOOTED pulse mid-pass aborts to IDLE with DONE and ERROR low.
    pulse_start(k);
    repeat (10) @(negedge clk);
    bus.N_BOOTED = 1'b1;
    @(negedge clk);
    bus.N_BOOTED = 1'b0;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    check("abort_error", 32'(bus.ERROR), 32'd0);
    check("abort_n_oe",
          32'({bus.ROM_N_OE, bus.SLICE_N_OE, bus.LOOKAHEAD_N_OE, bus.CONTROL_N_OE}), 32'hF);
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(bus.DONE), 32'd0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
